// File: rtl/sysid_check_pkg.sv
// rtl/sysid_check_pkg.sv - shared types and constants for the system-ID check controller
package sysid_check_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RD_ID,
      LAT_ID,
      RD_TS,
      LAT_TS,
      CHECK
   } state_t;

   localparam logic SYSID_ADDR_ID = 1'b0;
   localparam logic SYSID_ADDR_TS = 1'b1;
   localparam int   WAIT_CNT_W    = 16;

endpackage

// File: rtl/sysid_read_port.sv
// rtl/sysid_read_port.sv - single Avalon-MM read: waitrequest handshake, fixed read latency, stall timeout
module sysid_read_port
   import sysid_check_pkg::*;
#(
   parameter int READ_LATENCY   = 1,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic clock,
   input  logic reset,
   input  logic req,
   input  logic lat_en,
   input  logic avm_waitrequest,
   output logic avm_read,
   output logic accepted,
   output logic capture,
   output logic timeout
);

   localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [1:0] LAT_LAST = (READ_LATENCY > 0) ? 2'(READ_LATENCY - 1) : 2'd0;

   logic                  gap_q;
   logic [WAIT_CNT_W-1:0] wait_cnt;
   logic [1:0]            lat_cnt;

   // After a timeout the strobe drops for one cycle before the retry is issued
   assign avm_read = req && !gap_q;
   assign accepted = avm_read && !avm_waitrequest;
   assign timeout  = avm_read && avm_waitrequest && (wait_cnt == WAIT_LAST);
   assign capture  = (READ_LATENCY == 0) ? accepted : (lat_en && (lat_cnt == LAT_LAST));

   always_ff @(posedge clock) begin
      if (reset) begin
         gap_q    <= 1'b0;
         wait_cnt <= '0;
         lat_cnt  <= '0;
      end else begin
         gap_q <= timeout;
         if (!avm_read || accepted || timeout)
            wait_cnt <= '0;
         else
            wait_cnt <= wait_cnt + 1'b1;
         if (!lat_en)
            lat_cnt <= '0;
         else
            lat_cnt <= lat_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/sysid_check_ctrl.sv
// rtl/sysid_check_ctrl.sv - reads system-ID and timestamp words, compares them, reports pass/fail
// Optional SYSID_CHECK_PERIODIC_EN: re-run the check every 2^26 cycles while idle.
module sysid_check_ctrl
   import sysid_check_pkg::*;
#(
   parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
   parameter logic [31:0] EXPECTED_TS    = 32'd1547560866,
   parameter int          READ_LATENCY   = 1,
   parameter int          TIMEOUT_CYCLES = 255,
   parameter int          MAX_RETRIES    = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   output logic        avm_address,
   output logic        avm_read,
   input  logic        avm_waitrequest,
   input  logic [31:0] avm_readdata,
   output logic        busy,
   output logic        done,
   output logic        id_ok,
   output logic        ts_ok,
   output logic        timeout_err,
   output logic [31:0] id_value,
   output logic [31:0] ts_value
);

   localparam logic [2:0] RETRY_MAX = 3'(MAX_RETRIES);

   state_t     state_q, state_d;
   logic [2:0] retry_q;
   logic       trigger, launch, req, lat_en, word_ts;
   logic       accepted, capture, timeout;
   logic       fail_to, retry_inc;

`ifdef SYSID_CHECK_PERIODIC_EN
   logic [31:0] per_cnt;

   always_ff @(posedge clock) begin
      if (reset)
         per_cnt <= '0;
      else
         per_cnt <= per_cnt + 1'b1;
   end

   assign trigger = start || (per_cnt[25:0] == 26'h3FF_FFFF);
`else
   assign trigger = start;
`endif

   // busy still covers the done cycle, so a start coinciding with done is dropped
   assign launch  = trigger && (state_q == IDLE) && !busy;
   assign req     = (state_q == RD_ID) || (state_q == RD_TS);
   assign lat_en  = (state_q == LAT_ID) || (state_q == LAT_TS);
   assign word_ts = (state_q == RD_TS) || (state_q == LAT_TS);
   assign avm_address = word_ts ? SYSID_ADDR_TS : SYSID_ADDR_ID;

   sysid_read_port #(
      .READ_LATENCY   (READ_LATENCY),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_read_port (
      .clock           (clock),
      .reset           (reset),
      .req             (req),
      .lat_en          (lat_en),
      .avm_waitrequest (avm_waitrequest),
      .avm_read        (avm_read),
      .accepted        (accepted),
      .capture         (capture),
      .timeout         (timeout)
   );

   always_comb begin
      state_d   = state_q;
      fail_to   = 1'b0;
      retry_inc = 1'b0;
      case (state_q)
         IDLE:   if (launch) state_d = RD_ID;
         RD_ID, RD_TS: begin
            if (timeout) begin
               if (retry_q == RETRY_MAX) begin
                  fail_to = 1'b1;
                  state_d = IDLE;
               end else begin
                  retry_inc = 1'b1;
                  state_d   = RD_ID;
               end
            end else if (capture) begin
               state_d = (state_q == RD_ID) ? RD_TS : CHECK;
            end else if (accepted) begin
               state_d = (state_q == RD_ID) ? LAT_ID : LAT_TS;
            end
         end
         LAT_ID: if (capture) state_d = RD_TS;
         LAT_TS: if (capture) state_d = CHECK;
         CHECK:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         retry_q     <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         id_ok       <= 1'b0;
         ts_ok       <= 1'b0;
         timeout_err <= 1'b0;
         id_value    <= '0;
         ts_value    <= '0;
      end else begin
         state_q <= state_d;
         done    <= (state_q == CHECK) || fail_to;
         if (capture) begin
            if (word_ts)
               ts_value <= avm_readdata;
            else
               id_value <= avm_readdata;
         end
         if (launch) begin
            busy        <= 1'b1;
            retry_q     <= '0;
            id_ok       <= 1'b0;
            ts_ok       <= 1'b0;
            timeout_err <= 1'b0;
         end
         if (done)
            busy <= 1'b0;
         if (retry_inc && (retry_q != 3'h7))
            retry_q <= retry_q + 1'b1;
         if (state_q == CHECK) begin
            id_ok <= (id_value == EXPECTED_ID);
            ts_ok <= (ts_value == EXPECTED_TS);
         end
         if (fail_to) begin
            timeout_err <= 1'b1;
            id_ok       <= 1'b0;
            ts_ok       <= 1'b0;
         end
      end
   end

endmodule
